// File: rtl/reg_file_wb.sv
// reg_file_wb: architectural register file with a write-through bypass,
// a PC register at the top index, and a per-register pending-write
// scoreboard that produces busy/stall flags for the two read ports.
module reg_file_wb #(
   parameter int NREG = 8,
   parameter int DW   = 16,
   localparam int AW  = (NREG > 1) ? $clog2(NREG) : 1
) (
   input  logic          clk,
   input  logic          resetn,
   input  logic          wb_en,
   input  logic [AW-1:0] wb_addr,
   input  logic [DW-1:0] wb_data,
   input  logic [AW-1:0] rd_addr_a,
   input  logic [AW-1:0] rd_addr_b,
   output logic [DW-1:0] rd_data_a,
   output logic [DW-1:0] rd_data_b,
   input  logic          pc_wr_en,
   input  logic [DW-1:0] pc_next,
   output logic [DW-1:0] pc_out,
   input  logic          issue_en,
   input  logic [AW-1:0] issue_dest,
   input  logic          flush,
   output logic          busy_a,
   output logic          busy_b,
   output logic          stall,
   output logic          sb_err
);

   localparam logic [AW-1:0] PC_IDX = AW'(NREG - 1);

   logic [DW-1:0] regs          [NREG];
   logic [1:0]    pend_cnt      [NREG];
   logic [1:0]    pend_cnt_next [NREG];
   logic [NREG-1:0] inc_hit;
   logic [NREG-1:0] dec_hit;
   logic            err_set;
   logic            wb_hits_pc;

   assign wb_hits_pc = wb_en && (wb_addr == PC_IDX);

   // Decode which registers are being marked pending (issue) and which are
   // being resolved (write-back) this cycle.
   always_comb begin
      inc_hit = '0;
      dec_hit = '0;
      for (int r = 0; r < NREG; r++) begin
         inc_hit[r] = issue_en && (issue_dest == AW'(r));
         dec_hit[r] = wb_en && (wb_addr == AW'(r));
      end
   end

   // Next pending count per register; saturating at both ends, where a
   // saturated update instead raises the scoreboard error.
   always_comb begin
      err_set = 1'b0;
      for (int r = 0; r < NREG; r++) begin
         pend_cnt_next[r] = pend_cnt[r];
         if (inc_hit[r] && !dec_hit[r]) begin
            if (pend_cnt[r] == 2'd3) begin
               err_set = 1'b1;
            end else begin
               pend_cnt_next[r] = pend_cnt[r] + 2'd1;
            end
         end else if (dec_hit[r] && !inc_hit[r]) begin
            if (pend_cnt[r] == 2'd0) begin
               err_set = 1'b1;
            end else begin
               pend_cnt_next[r] = pend_cnt[r] - 2'd1;
            end
         end
      end
   end

   // Register storage; a write-back to the PC slot beats a sequential PC update.
   always_ff @(posedge clk) begin
      if (!resetn) begin
         for (int r = 0; r < NREG; r++) begin
            regs[r] <= '0;
         end
      end else begin
         if (wb_en) begin
            regs[wb_addr] <= wb_data;
         end
         if (pc_wr_en && !wb_hits_pc) begin
            regs[PC_IDX] <= pc_next;
         end
      end
   end

   // Pending counters; a flush discards every outstanding mark.
   always_ff @(posedge clk) begin
      if (!resetn) begin
         for (int r = 0; r < NREG; r++) begin
            pend_cnt[r] <= 2'd0;
         end
      end else begin
         for (int r = 0; r < NREG; r++) begin
            pend_cnt[r] <= flush ? 2'd0 : pend_cnt_next[r];
         end
      end
   end

   // Sticky scoreboard error; a flush overrides the counter effects of the
   // same cycle, so saturation is not flagged then, and only reset clears it.
   always_ff @(posedge clk) begin
      if (!resetn) begin
         sb_err <= 1'b0;
      end else if (err_set && !flush) begin
         sb_err <= 1'b1;
      end
   end

   assign rd_data_a = (wb_en && (wb_addr == rd_addr_a)) ? wb_data : regs[rd_addr_a];
   assign rd_data_b = (wb_en && (wb_addr == rd_addr_b)) ? wb_data : regs[rd_addr_b];
   assign pc_out    = regs[PC_IDX];

   assign busy_a = (pend_cnt[rd_addr_a] != 2'd0) &&
                   !((pend_cnt[rd_addr_a] == 2'd1) && wb_en && (wb_addr == rd_addr_a));
   assign busy_b = (pend_cnt[rd_addr_b] != 2'd0) &&
                   !((pend_cnt[rd_addr_b] == 2'd1) && wb_en && (wb_addr == rd_addr_b));
   assign stall  = busy_a || busy_b;

endmodule

// File: tb/tb_reg_file_wb.sv
// tb_reg_file_wb: directed vectors with hand-computed expectations for
// the register file, its bypass, the PC slot and the pending scoreboard.
module tb_reg_file_wb;

   logic        clk;
   logic        resetn;
   logic        wb_en;
   logic [2:0]  wb_addr;
   logic [15:0] wb_data;
   logic [2:0]  rd_addr_a;
   logic [2:0]  rd_addr_b;
   logic [15:0] rd_data_a;
   logic [15:0] rd_data_b;
   logic        pc_wr_en;
   logic [15:0] pc_next;
   logic [15:0] pc_out;
   logic        issue_en;
   logic [2:0]  issue_dest;
   logic        flush;
   logic        busy_a;
   logic        busy_b;
   logic        stall;
   logic        sb_err;

   int check_count = 0;
   int error_count = 0;

   reg_file_wb #(.NREG(8), .DW(16)) dut (
      .clk        (clk),
      .resetn     (resetn),
      .wb_en      (wb_en),
      .wb_addr    (wb_addr),
      .wb_data    (wb_data),
      .rd_addr_a  (rd_addr_a),
      .rd_addr_b  (rd_addr_b),
      .rd_data_a  (rd_data_a),
      .rd_data_b  (rd_data_b),
      .pc_wr_en   (pc_wr_en),
      .pc_next    (pc_next),
      .pc_out     (pc_out),
      .issue_en   (issue_en),
      .issue_dest (issue_dest),
      .flush      (flush),
      .busy_a     (busy_a),
      .busy_b     (busy_b),
      .stall      (stall),
      .sb_err     (sb_err)
   );

   // Free-running clock, period 10.
   initial clk = 1'b0;
   always #5 clk = ~clk;

   task automatic checkOutput(input string tag, input logic [15:0] observed,
                              input logic [15:0] expected);
      check_count++;
      if (observed !== expected) begin
         error_count++;
         $display("[TB] FAIL %s: observed %h expected %h", tag, observed, expected);
      end
   endtask

   task automatic applyStimulus(input logic we, input logic [2:0] wa, input logic [15:0] wd,
                                input logic pe, input logic [15:0] pn,
                                input logic ie, input logic [2:0] id, input logic fl);
      wb_en      = we;
      wb_addr    = wa;
      wb_data    = wd;
      pc_wr_en   = pe;
      pc_next    = pn;
      issue_en   = ie;
      issue_dest = id;
      flush      = fl;
      #1;
   endtask

   task automatic idle();
      applyStimulus(1'b0, 3'd0, 16'h0000, 1'b0, 16'h0000, 1'b0, 3'd0, 1'b0);
   endtask

   task automatic tick();
      @(posedge clk);
      #1;
   endtask

   task automatic doReset();
      idle();
      resetn = 1'b0;
      tick();
      tick();
      resetn = 1'b1;
      #1;
   endtask

   initial begin
      resetn    = 1'b0;
      rd_addr_a = 3'd0;
      rd_addr_b = 3'd0;
      doReset();

      for (int a = 0; a < 8; a++) begin
         rd_addr_a = 3'(a);
         rd_addr_b = 3'(a);
         #1;
         checkOutput($sformatf("reset_rd_a_%0d", a), rd_data_a, 16'h0000);
         checkOutput($sformatf("reset_busy_b_%0d", a), {15'd0, busy_b}, 16'd0);
      end
      checkOutput("reset_pc_out", pc_out, 16'h0000);
      checkOutput("reset_stall", {15'd0, stall}, 16'd0);
      checkOutput("reset_sb_err", {15'd0, sb_err}, 16'd0);

      rd_addr_a = 3'd3;
      rd_addr_b = 3'd3;
      applyStimulus(1'b1, 3'd3, 16'hBEEF, 1'b0, 16'h0, 1'b0, 3'd0, 1'b0);
      checkOutput("bypass_rd_a", rd_data_a, 16'hBEEF);
      tick();
      idle();
      checkOutput("stored_rd_a", rd_data_a, 16'hBEEF);
      checkOutput("underflow_sb_err", {15'd0, sb_err}, 16'd1);
      applyStimulus(1'b1, 3'd3, 16'h1111, 1'b0, 16'h0, 1'b0, 3'd0, 1'b0);
      checkOutput("bypass_rd_b_new", rd_data_b, 16'h1111);
      idle();
      checkOutput("bypass_released_rd_b", rd_data_b, 16'hBEEF);

      doReset();
      rd_addr_a = 3'd0;
      rd_addr_b = 3'd2;
      applyStimulus(1'b0, 3'd0, 16'h0, 1'b0, 16'h0, 1'b1, 3'd2, 1'b0);
      checkOutput("issue_same_cycle_busy_b", {15'd0, busy_b}, 16'd0);
      tick();
      idle();
      checkOutput("pending_busy_b", {15'd0, busy_b}, 16'd1);
      checkOutput("pending_stall", {15'd0, stall}, 16'd1);
      checkOutput("pending_busy_a_other", {15'd0, busy_a}, 16'd0);
      applyStimulus(1'b1, 3'd2, 16'h0042, 1'b0, 16'h0, 1'b0, 3'd0, 1'b0);
      checkOutput("resolve_busy_b", {15'd0, busy_b}, 16'd0);
      checkOutput("resolve_stall", {15'd0, stall}, 16'd0);
      checkOutput("resolve_rd_b", rd_data_b, 16'h0042);
      tick();
      idle();
      checkOutput("cleared_busy_b", {15'd0, busy_b}, 16'd0);
      checkOutput("cleared_rd_b", rd_data_b, 16'h0042);
      checkOutput("clean_sb_err", {15'd0, sb_err}, 16'd0);

      rd_addr_a = 3'd7;
      applyStimulus(1'b1, 3'd7, 16'h1234, 1'b1, 16'h0010, 1'b0, 3'd0, 1'b0);
      checkOutput("pc_no_bypass", pc_out, 16'h0000);
      checkOutput("r7_bypass_rd_a", rd_data_a, 16'h1234);
      tick();
      idle();
      checkOutput("pc_wb_priority", pc_out, 16'h1234);
      applyStimulus(1'b0, 3'd0, 16'h0, 1'b1, 16'h0010, 1'b0, 3'd0, 1'b0);
      checkOutput("pc_hold_before_edge", pc_out, 16'h1234);
      checkOutput("r7_rd_a_stored", rd_data_a, 16'h1234);
      tick();
      idle();
      checkOutput("pc_seq_update", pc_out, 16'h0010);
      checkOutput("pc_seq_rd_a", rd_data_a, 16'h0010);

      doReset();
      rd_addr_a = 3'd5;
      rd_addr_b = 3'd0;
      for (int k = 0; k < 3; k++) begin
         applyStimulus(1'b0, 3'd0, 16'h0, 1'b0, 16'h0, 1'b1, 3'd5, 1'b0);
         tick();
      end
      idle();
      checkOutput("three_issues_sb_err", {15'd0, sb_err}, 16'd0);
      applyStimulus(1'b0, 3'd0, 16'h0, 1'b0, 16'h0, 1'b1, 3'd5, 1'b0);
      tick();
      idle();
      checkOutput("saturate_sb_err", {15'd0, sb_err}, 16'd1);
      checkOutput("saturate_busy_a", {15'd0, busy_a}, 16'd1);
      applyStimulus(1'b1, 3'd5, 16'h9999, 1'b0, 16'h0, 1'b0, 3'd0, 1'b0);
      checkOutput("cnt3_wb_still_busy", {15'd0, busy_a}, 16'd1);
      applyStimulus(1'b1, 3'd0, 16'h0A0A, 1'b0, 16'h0, 1'b1, 3'd5, 1'b1);
      tick();
      idle();
      checkOutput("flush_busy_a", {15'd0, busy_a}, 16'd0);
      checkOutput("flush_stall", {15'd0, stall}, 16'd0);
      checkOutput("flush_sb_err_sticky", {15'd0, sb_err}, 16'd1);
      checkOutput("flush_wb_write", rd_data_b, 16'h0A0A);

      doReset();
      rd_addr_a = 3'd1;
      rd_addr_b = 3'd4;
      applyStimulus(1'b0, 3'd0, 16'h0, 1'b0, 16'h0, 1'b1, 3'd1, 1'b0);
      tick();
      applyStimulus(1'b1, 3'd1, 16'h5555, 1'b0, 16'h0, 1'b1, 3'd1, 1'b0);
      tick();
      idle();
      checkOutput("inc_dec_busy_a", {15'd0, busy_a}, 16'd1);
      checkOutput("inc_dec_rd_a", rd_data_a, 16'h5555);
      checkOutput("inc_dec_sb_err", {15'd0, sb_err}, 16'd0);
      applyStimulus(1'b1, 3'd1, 16'h6666, 1'b0, 16'h0, 1'b0, 3'd0, 1'b0);
      checkOutput("cnt1_wb_busy_a", {15'd0, busy_a}, 16'd0);
      applyStimulus(1'b0, 3'd0, 16'h0, 1'b0, 16'h0, 1'b1, 3'd1, 1'b0);
      tick();
      applyStimulus(1'b1, 3'd1, 16'h6666, 1'b0, 16'h0, 1'b0, 3'd0, 1'b0);
      checkOutput("cnt2_wb_busy_a", {15'd0, busy_a}, 16'd1);
      applyStimulus(1'b1, 3'd4, 16'hABCD, 1'b0, 16'h0, 1'b0, 3'd0, 1'b0);
      tick();
      idle();
      checkOutput("wb_cnt0_sb_err", {15'd0, sb_err}, 16'd1);
      checkOutput("wb_cnt0_write", rd_data_b, 16'hABCD);

      rd_addr_a = 3'd6;
      applyStimulus(1'b1, 3'd6, 16'hFFFF, 1'b0, 16'h0, 1'b1, 3'd3, 1'b0);
      tick();
      idle();
      checkOutput("pre_reset_r6", rd_data_a, 16'hFFFF);
      resetn = 1'b0;
      applyStimulus(1'b1, 3'd2, 16'h7777, 1'b1, 16'h00AA, 1'b1, 3'd6, 1'b0);
      tick();
      resetn = 1'b1;
      idle();
      for (int a = 0; a < 8; a++) begin
         rd_addr_a = 3'(a);
         #1;
         checkOutput($sformatf("midreset_rd_a_%0d", a), rd_data_a, 16'h0000);
         checkOutput($sformatf("midreset_stall_%0d", a), {15'd0, stall}, 16'd0);
      end
      checkOutput("midreset_pc_out", pc_out, 16'h0000);
      checkOutput("midreset_sb_err", {15'd0, sb_err}, 16'd0);

      $display("Simulation finished: %0d checks, %0d errors", check_count, error_count);
      $finish;
   end

endmodule

// File: doc/reg_file_wb.md
REG_FILE_WB -- requirements
Module: reg_file_wb

Interface
REQ-001 Parameter NREG, default 8: number of architectural registers; R(NREG-1) is the PC.
REQ-002 Parameter DW, default 16: register data width.
REQ-003 clk  input  1  rising-edge clock for all state.
REQ-004 resetn  input  1  reset, synchronous, active-low.
REQ-005 wb_en  input  1  write-back valid for this cycle.
REQ-006 wb_addr  input  3  write-back destination register.
REQ-007 wb_data  input  16  write-back value.
REQ-008 rd_addr_a, rd_addr_b  input  3 each  read-port source registers.
REQ-009 rd_data_a, rd_data_b  output  16 each  read-port values, combinational.
REQ-010 pc_wr_en  input  1  sequential PC update request.
REQ-011 pc_next  input  16  next PC value for pc_wr_en.
REQ-012 pc_out  output  16  current R7 contents.
REQ-013 issue_en  input  1  decode issues an instruction that writes issue_dest.
REQ-014 issue_dest  input  3  destination marked pending on issue.
REQ-015 flush  input  1  pipeline flush; discards all pending marks.
REQ-016 busy_a, busy_b  output  1 each  source A/B has an unresolved pending write.
REQ-017 stall  output  1  busy_a OR busy_b.
REQ-018 sb_err  output  1  sticky scoreboard overflow/underflow flag.

Function
REQ-019 Storage SHALL be NREG registers of DW bits; wb_en writes wb_data into wb_addr at the rising edge.
REQ-020 Reads SHALL be combinational; if wb_en=1 and wb_addr equals the read address, the port SHALL return wb_data (write-through bypass), else the stored value.
REQ-021 Reading address 7 SHALL obey REQ-020 (the bypass applies to R7 too); pc_out SHALL show the stored R7 only, without bypass.
REQ-022 R7 update: wb_en with wb_addr=7 SHALL take priority over pc_wr_en in the same cycle; otherwise pc_wr_en loads pc_next into R7.
REQ-023 Each register SHALL have a 2-bit pending counter (0..3), reset to 0.
REQ-024 Counter update per edge: issue_en to reg r increments; wb_en to reg r decrements; both to same r in one cycle leaves it unchanged.
REQ-025 Increment at 3 SHALL hold 3 and set sb_err; decrement at 0 SHALL hold 0 and set sb_err.
REQ-026 flush=1 SHALL clear all counters to 0 at the edge, overriding concurrent issue_en/wb_en counter effects; the register write from wb_en SHALL still occur.
REQ-027 busy_x SHALL be 1 when counter[rd_addr_x] > 0, except busy_x SHALL be 0 when counter equals 1 and wb_en=1 with wb_addr=rd_addr_x (value available via bypass).
REQ-028 busy/stall SHALL be combinational from current counters and current wb inputs; issue_en in the same cycle does not affect them until the next cycle.
REQ-029 sb_err SHALL stay 1 until reset; flush does not clear it.

Reset
REQ-030 On clk edge with resetn=0: all registers including R7 = 0, all counters = 0, sb_err = 0; wb_en, pc_wr_en, issue_en and flush SHALL be ignored that cycle.
REQ-031 Reset asserted mid-operation SHALL discard outstanding pending marks; after release, rd_data_a/b = 0 and stall = 0 for every address until written.

Verification
REQ-032 Reset, then wb_en=1 wb_addr=3 wb_data=16'hBEEF with rd_addr_a=3 -> rd_data_a=16'hBEEF same cycle; next cycle, wb_en=0 -> rd_data_a=16'hBEEF from storage.
REQ-033 issue_en dest=2 at cycle 0; cycle 1 rd_addr_b=2 -> busy_b=1, stall=1; cycle 2 wb_en addr=2 data=16'h0042 -> busy_b=0, rd_data_b=16'h0042; cycle 3 counter=0.
REQ-034 Same cycle: wb_en addr=7 data=16'h1234 and pc_wr_en pc_next=16'h0010 -> pc_out=16'h1234 next cycle.
REQ-035 Four issue_en to dest=5 with no write-back -> counter saturates at 3, sb_err=1; then flush -> counter=0, busy=0, sb_err stays 1.
REQ-036 wb_en addr=4 with counter[4]=0 -> sb_err=1, register 4 written; and simultaneous issue_en dest=1 plus wb_en addr=1 with counter 1 -> counter stays 1.
REQ-037 Assert resetn=0 while counters nonzero and R6=16'hFFFF -> next cycle all outputs 0, stall=0.
